// File: rtl/mtm_alu_deserializer_fifo.sv
// Serial frame receiver (start, type, MSB-first payload, stop) that queues each good
// frame as {type, payload} in a small FIFO, flagging framing errors and FIFO overflow.
module mtm_alu_deserializer_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sin,
  output logic [DATA_W:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_err,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP, RECOVER} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W:0]     shift_q, shift_d;
  logic                push_q, push_d;
  logic                ferr_q, ferr_d;
  logic                ovf_q, ovf_d;

  logic [DATA_W:0]     mem [DEPTH];
  logic [PW-1:0]       wr_q, wr_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic [LW-1:0]       level_q, level_d;

  logic                pop;
  logic                full;
  logic                do_write;

  // Receive FSM: one serial bit per clock
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!sin) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d = {shift_q[DATA_W-1:0], sin};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W)) state_d = STOP;
      end
      STOP: begin
        if (sin) begin
          push_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (sin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The pushed word is taken from shift_q one cycle after the stop bit; the
  // shifter does not move again until the next frame's first data bit.
  always_comb begin
    pop      = out_valid && out_ready;
    full     = (level_q == LW'(DEPTH));
    do_write = push_q && (!full || pop);
    ovf_d    = push_q && full && !pop;
    wr_d     = do_write ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    level_d  = level_q;
    if (do_write && !pop)      level_d = level_q + 1'b1;
    else if (!do_write && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // When full with a simultaneous pop, wr_q == rd_q: the freed head slot becomes the new tail
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_q] <= shift_q;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_q] : '0;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;
  assign level     = level_q;

endmodule

// File: tb/tb_mtm_alu_deserializer_fifo.sv
// Directed bench for the serial deserializer FIFO (DATA_W=8, DEPTH=4).
module tb_mtm_alu_deserializer_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       out_ready;
  logic [8:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       overflow;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  mtm_alu_deserializer_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start, type, 8 payload bits MSB first, stop; each bit sampled at the following posedge
  task automatic send_frame(input logic t, input logic [7:0] p, input logic stop);
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = t;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); sin = p[i];
    end
    @(negedge clk); sin = stop;
  endtask

  initial begin
    rst = 1'b1; sin = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Single good frame, 11-clock latency, one-cycle valid with ready high
    send_frame(1'b0, 8'hA5, 1'b1);
    @(negedge clk); sin = 1'b1;
    chk("t1_early_valid", out_valid, 0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 9'h0A5);
    chk("t1_level", level, 1);
    @(negedge clk);
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_level_drop", level, 0);

    // Bad stop bit, low line in recovery, then a good frame
    send_frame(1'b1, 8'hFF, 1'b0);
    @(negedge clk); sin = 1'b0;
    chk("t2_ferr", frame_err, 1);
    chk("t2_level", level, 0);
    @(negedge clk); sin = 1'b0;
    chk("t2_ferr_pulse", frame_err, 0);
    repeat (3) begin
      @(negedge clk); sin = 1'b0;
    end
    @(negedge clk); sin = 1'b1;
    @(negedge clk); sin = 1'b1;
    chk("t2_recover_level", level, 0);
    send_frame(1'b1, 8'h01, 1'b1);
    @(negedge clk); sin = 1'b1;
    @(negedge clk);
    chk("t2_valid", out_valid, 1);
    chk("t2_data", out_data, 9'h101);
    chk("t2_ferr_good", frame_err, 0);
    @(negedge clk);

    // Five back-to-back frames with no consumer: fifth is dropped
    out_ready = 1'b0;
    for (int f = 1; f <= 5; f++) send_frame(1'b0, 8'(f), 1'b1);
    @(negedge clk); sin = 1'b1;
    chk("t3_level_full", level, 4);
    chk("t3_ovf_early", overflow, 0);
    @(negedge clk);
    chk("t3_ovf", overflow, 1);
    chk("t3_level_keep", level, 4);
    chk("t3_ferr", frame_err, 0);
    @(negedge clk);
    chk("t3_ovf_pulse", overflow, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain", out_data, i);
      @(negedge clk);
    end
    chk("t3_empty", out_valid, 0);
    chk("t3_empty_level", level, 0);

    // Full FIFO with a pop in the same cycle as the fifth push
    out_ready = 1'b0;
    for (int f = 1; f <= 5; f++) send_frame(1'b0, 8'(8'h10 + f), 1'b1);
    @(negedge clk); sin = 1'b1; out_ready = 1'b1;
    chk("t4_level_full", level, 4);
    @(negedge clk); out_ready = 1'b0;
    chk("t4_ovf", overflow, 0);
    chk("t4_level", level, 4);
    chk("t4_head", out_data, 9'h012);
    @(negedge clk);
    chk("t4_ovf_late", overflow, 0);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("t4_drain", out_data, 9'h010 + i);
      @(negedge clk);
    end
    chk("t4_empty", out_valid, 0);

    // Reset in the middle of a frame
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = 1'b1;
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = 1'b1;
    @(negedge clk); sin = 1'b1;
    @(negedge clk); rst = 1'b1; sin = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_ferr", frame_err, 0);
    chk("t5_rst_ovf", overflow, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); sin = 1'b1;
      chk("t5_nopush", {out_valid, frame_err, overflow, level}, 0);
    end
    send_frame(1'b0, 8'h3C, 1'b1);
    @(negedge clk); sin = 1'b1;
    @(negedge clk);
    chk("t5_valid", out_valid, 1);
    chk("t5_data", out_data, 9'h03C);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
